// File: rtl/nand_cell_tester_if.sv
// Signal bundle between the NAND cell tester and its environment.
// The master side is the tester; the slave side drives start and the cell output w.
interface nand_cell_tester_if;
   logic       start;
   logic       a;
   logic       b;
   logic       w;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] err_count;
   logic [3:0] fail_vec;
   logic [3:0] delay_max;

   modport master (
      input  start, w,
      output a, b, busy, done, pass, err_count, fail_vec, delay_max
   );

   modport slave (
      output start, w,
      input  a, b, busy, done, pass, err_count, fail_vec, delay_max
   );
endinterface

// File: rtl/nand_cell_tester.sv
// Drives a NAND cell through 00,01,11,10, checks w and measures settle cycles.
// Define NAND_CELL_TESTER_SYNC_EN to pass w through a two-flop synchroniser first.
module nand_cell_tester #(
   parameter int unsigned SETTLE_CYCLES = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   nand_cell_tester_if.master bus_if
);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_WAIT, S_DONE} state_e;

   localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

   logic w_s;

`ifdef NAND_CELL_TESTER_SYNC_EN
   // Samples taken before the synchroniser has flushed reflect the old vector.
   localparam logic [3:0] SYNC_LAT = 4'd2;

   logic w_meta_q;
   logic w_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_meta_q <= 1'b1;
         w_sync_q <= 1'b1;
      end else begin
         w_meta_q <= bus_if.w;
         w_sync_q <= w_meta_q;
      end
   end

   assign w_s = w_sync_q;
`else
   localparam logic [3:0] SYNC_LAT = 4'd0;

   assign w_s = bus_if.w;
`endif

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] d_q, d_d;
   logic       a_q, a_d;
   logic       b_q, b_d;
   logic       pass_q, pass_d;
   logic [2:0] err_q, err_d;
   logic [3:0] fail_q, fail_d;
   logic [3:0] dmax_q, dmax_d;

   logic       vec_a;
   logic       vec_b;
   logic       exp_w;
   logic [3:0] d_inc;
   logic       vec_end;

   always_comb begin
      unique case (idx_q)
         2'd0:    {vec_a, vec_b} = 2'b00;
         2'd1:    {vec_a, vec_b} = 2'b01;
         2'd2:    {vec_a, vec_b} = 2'b11;
         default: {vec_a, vec_b} = 2'b10;
      endcase
   end

   assign exp_w = ~(vec_a & vec_b);
   assign d_inc = d_q + 4'd1;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      d_d     = d_q;
      a_d     = a_q;
      b_d     = b_q;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;
      dmax_d  = dmax_q;
      vec_end = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus_if.start) begin
               pass_d  = 1'b0;
               err_d   = 3'd0;
               fail_d  = 4'd0;
               dmax_d  = 4'd0;
               idx_d   = 2'd0;
               state_d = S_APPLY;
            end
         end

         S_APPLY: begin
            a_d     = vec_a;
            b_d     = vec_b;
            d_d     = 4'd0;
            state_d = S_WAIT;
         end

         S_WAIT: begin
            d_d = d_inc;
            // A match on the timeout edge still counts as a pass.
            if ((d_inc > SYNC_LAT) && (w_s == exp_w)) begin
               if (d_inc > dmax_q) begin
                  dmax_d = d_inc;
               end
               vec_end = 1'b1;
            end else if (d_inc >= SETTLE_MAX) begin
               fail_d[idx_q] = 1'b1;
               err_d         = err_q + 3'd1;
               vec_end       = 1'b1;
            end

            if (vec_end) begin
               if (idx_q == 2'd3) begin
                  a_d     = 1'b1;
                  b_d     = 1'b1;
                  pass_d  = (err_d == 3'd0);
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_APPLY;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         d_q     <= 4'd0;
         a_q     <= 1'b1;
         b_q     <= 1'b1;
         pass_q  <= 1'b0;
         err_q   <= 3'd0;
         fail_q  <= 4'd0;
         dmax_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         d_q     <= d_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         dmax_q  <= dmax_d;
      end
   end

   assign bus_if.a         = a_q;
   assign bus_if.b         = b_q;
   assign bus_if.busy      = (state_q == S_APPLY) || (state_q == S_WAIT);
   assign bus_if.done      = (state_q == S_DONE);
   assign bus_if.pass      = pass_q;
   assign bus_if.err_count = err_q;
   assign bus_if.fail_vec  = fail_q;
   assign bus_if.delay_max = dmax_q;

endmodule

// File: tb/tb_nand_cell_tester.sv
// Bench for nand_cell_tester: a cell model with programmable cycle delay or stuck output,
// and a reference model that replays the vector timeline from the NAND truth table.
module tb_nand_cell_tester;

   localparam int SETTLE = 6;
`ifdef NAND_CELL_TESTER_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   nand_cell_tester_if bus_if ();

   nand_cell_tester #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_if (bus_if)
   );

   // Cell model: mode 0 = NAND delayed by kdel edges, 1 = stuck at 1, 2 = stuck at 0.
   int         mode = 0;
   int         kdel = 0;
   logic [7:0] pipe = 8'h00;

   always @(posedge clk) pipe <= {pipe[6:0], ~(bus_if.a & bus_if.b)};

   always_comb begin
      case (mode)
         1:       bus_if.w = 1'b1;
         2:       bus_if.w = 1'b0;
         default: bus_if.w = (kdel == 0) ? ~(bus_if.a & bus_if.b) : pipe[kdel-1];
      endcase
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: drive history indexed by edge, vector 0 registered at edge 0.
   logic [1:0] vec_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   logic [1:0] mdl_drv [$];

   function automatic logic cell_at(input int e, input int m, input int k);
      logic [1:0] v;
      int         i;
      if (m == 1) return 1'b1;
      if (m == 2) return 1'b0;
      i = e - k - 1;
      v = (i < 0) ? 2'b11 : mdl_drv[i];
      return ~(v[1] & v[0]);
   endfunction

   task automatic model_run(input int m, input int k, output logic [3:0] fv, output logic [2:0] ec,
                            output logic ps, output logic [3:0] dm, output int cyc);
      int         e;
      int         j;
      bit         hit;
      logic [1:0] v;
      logic       expw;
      mdl_drv.delete();
      e   = 0;
      cyc = 1;
      fv  = '0;
      ec  = '0;
      dm  = '0;
      for (int vi = 0; vi < 4; vi++) begin
         v    = vec_tab[vi];
         expw = ~(v[1] & v[0]);
         mdl_drv.push_back(v);
         hit = 1'b0;
         j   = 0;
         while (!hit && j < SETTLE) begin
            j++;
            mdl_drv.push_back(v);
            if (j > LAT && cell_at(e + j - LAT, m, k) == expw) hit = 1'b1;
         end
         if (hit) begin
            if (j > int'(dm)) dm = 4'(j);
         end else begin
            fv[vi] = 1'b1;
            ec     = ec + 3'd1;
         end
         cyc += 1 + j;
         e   += j + 1;
      end
      ps = (ec == 3'd0);
   endtask

   // One run: returns cycles from the first APPLY cycle through DONE (-1 on timeout).
   task automatic do_run(input int m, input int k, output int cyc);
      mode = m;
      kdel = k;
      repeat (12) @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      check("busy_in_run", bus_if.busy, 1);
      cyc = 1;
      while (bus_if.done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (bus_if.done !== 1'b1) cyc = -1;
      @(negedge clk);
      check("done_one_cycle", bus_if.done, 0);
      check("busy_after_run", bus_if.busy, 0);
   endtask

   task automatic check_results(input string tag, input int m, input int k, input int cyc);
      logic [3:0] fv;
      logic [2:0] ec;
      logic       ps;
      logic [3:0] dm;
      int         ecyc;
      model_run(m, k, fv, ec, ps, dm, ecyc);
      check({tag, "_cycles"}, cyc, ecyc);
      check({tag, "_fail_vec"}, bus_if.fail_vec, fv);
      check({tag, "_err_count"}, bus_if.err_count, ec);
      check({tag, "_pass"}, bus_if.pass, ps);
      check({tag, "_delay_max"}, bus_if.delay_max, dm);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_a"}, bus_if.a, 1);
      check({tag, "_b"}, bus_if.b, 1);
      check({tag, "_busy"}, bus_if.busy, 0);
      check({tag, "_done"}, bus_if.done, 0);
      check({tag, "_pass"}, bus_if.pass, 0);
      check({tag, "_err_count"}, bus_if.err_count, 0);
      check({tag, "_fail_vec"}, bus_if.fail_vec, 0);
      check({tag, "_delay_max"}, bus_if.delay_max, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int ndone;
      int done_at;
      bit seen_a0;
      bit found;

      rst_n        = 1'b0;
      bus_if.start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;

      // Zero-delay cell: minimum run.
      do_run(0, 0, cyc);
      check("ideal_cycles", cyc, 4 * (2 + LAT) + 1);
      check("ideal_pass", bus_if.pass, 1);
      check("ideal_err_count", bus_if.err_count, 0);
      check("ideal_fail_vec", bus_if.fail_vec, 4'b0000);
      check("ideal_delay_max", bus_if.delay_max, 1 + LAT);

      // 25 ns cell with a 10 ns clock behaves as two edges of delay.
      do_run(0, 2, cyc);
      check("delay25_pass", bus_if.pass, 1);
      check("delay25_delay_max", bus_if.delay_max, 3 + LAT);

      // Stuck at 1: vector 11 times out.
      do_run(1, 0, cyc);
      check("stuck1_cycles", cyc, 3 * (2 + LAT) + (1 + SETTLE) + 1);
      check("stuck1_fail_vec", bus_if.fail_vec, 4'b0100);
      check("stuck1_err_count", bus_if.err_count, 1);
      check("stuck1_pass", bus_if.pass, 0);

      // Stuck at 0: only vector 11 passes.
      do_run(2, 0, cyc);
      check("stuck0_fail_vec", bus_if.fail_vec, 4'b1011);
      check("stuck0_err_count", bus_if.err_count, 3);
      check("stuck0_pass", bus_if.pass, 0);
      check("stuck0_delay_max", bus_if.delay_max, 1 + LAT);

      // Settle-limit boundary: exactly SETTLE passes, one more fails.
      do_run(0, SETTLE - 1 - LAT, cyc);
      check_results("limit_edge", 0, SETTLE - 1 - LAT, cyc);
      do_run(0, SETTLE - LAT, cyc);
      check_results("limit_over", 0, SETTLE - LAT, cyc);

      // start pulses while busy are ignored.
      mode = 0;
      kdel = 3;
      repeat (12) @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      ndone   = 0;
      done_at = -1;
      for (int c = 1; c <= 40; c++) begin
         if (bus_if.done === 1'b1) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         bus_if.start = (c == 3 || c == 9);
         @(negedge clk);
      end
      bus_if.start = 1'b0;
      check("busy_start_done_count", ndone, 1);
      check_results("busy_start", 0, 3, done_at);

      // Reset during vector index 2.
      mode = 0;
      kdel = 0;
      repeat (12) @(negedge clk);
      bus_if.start = 1'b1;
      @(negedge clk);
      bus_if.start = 1'b0;
      seen_a0 = 1'b0;
      found   = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         if (bus_if.a === 1'b0) seen_a0 = 1'b1;
         if (seen_a0 && bus_if.a === 1'b1 && bus_if.b === 1'b1 && bus_if.busy === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      check("reach_vec2", found, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus_if.done === 1'b1) ndone++;
      end
      check("midrun_no_done", ndone, 0);
      do_run(0, 0, cyc);
      check_results("after_reset", 0, 0, cyc);

      // Randomised cells against the reference model.
      for (int i = 0; i < 16; i++) begin
         int m;
         int k;
         int sel;
         sel = int'($urandom_range(0, 9));
         m   = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
         k   = int'($urandom_range(0, 7));
         do_run(m, k, cyc);
         check_results($sformatf("rnd%0d_m%0d_k%0d", i, m, k), m, k, cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
